// File: rtl/or_switch.sv
// rtl/or_switch.sv - switch-level CMOS 2-input OR array with registered output
// Optional input register stage enabled by defining OR_SWITCH_PIPE_EN.
module or_switch #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output wire  [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y
);

  supply1 vdd;
  supply0 gnd;

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;

`ifdef OR_SWITCH_PIPE_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign a_s = a_q;
  assign b_s = b_q;
`else
  assign a_s = a;
  assign b_s = b;
`endif

  // Per lane: NOR (series pull-up, parallel pull-down) then CMOS inverter.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      wire w;
      wire n;

      pmos p_a   (w, vdd, a_s[i]);
      pmos p_b   (n, w, b_s[i]);
      nmos n_a   (n, gnd, a_s[i]);
      nmos n_b   (n, gnd, b_s[i]);

      pmos p_inv (y_comb[i], vdd, n);
      nmos n_inv (y_comb[i], gnd, n);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else begin
      y <= y_comb;
    end
  end

endmodule

// File: tb/tb_or_switch.sv
// tb/tb_or_switch.sv - directed self-checking bench for or_switch (WIDTH=4)
// Expected latencies follow OR_SWITCH_PIPE_EN when it is defined for the build.
module tb_or_switch;

`ifdef OR_SWITCH_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  wire  [3:0] y_comb;
  logic [3:0] y;

  int checks;
  int failures;

  or_switch #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .y_comb (y_comb),
    .y      (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] exp_comb;
    rst_n = 1'b0;
    a = 4'b1111;
    b = 4'b1111;
    #1;
    checks++;
    if (y !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async_y: got %b want 0000", y);
    end
    exp_comb = (LAT == 1) ? 4'b1111 : 4'b0000;
    checks++;
    if (y_comb !== exp_comb) begin
      failures++;
      $display("FAIL reset_y_comb: got %b want %b", y_comb, exp_comb);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold_y: got %b want 0000", y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (y !== 4'b1111) begin
      failures++;
      $display("FAIL reset_release_y: got %b want 1111", y);
    end
  endtask

  task automatic test_truth_table();
    logic [3:0] va [6];
    logic [3:0] vb [6];
    logic [3:0] ve [6];
    logic [3:0] prev;
    logic [3:0] exp_now;
    va[0] = 4'b0000; vb[0] = 4'b0000; ve[0] = 4'b0000;
    va[1] = 4'b0011; vb[1] = 4'b0101; ve[1] = 4'b0111;
    va[2] = 4'b1010; vb[2] = 4'b0110; ve[2] = 4'b1110;
    va[3] = 4'b1111; vb[3] = 4'b0000; ve[3] = 4'b1111;
    va[4] = 4'b0000; vb[4] = 4'b1111; ve[4] = 4'b1111;
    va[5] = 4'b1000; vb[5] = 4'b0001; ve[5] = 4'b1001;
    prev = a | b;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a = va[k];
      b = vb[k];
      #1;
      exp_now = (LAT == 1) ? ve[k] : prev;
      checks++;
      if (y_comb !== exp_now) begin
        failures++;
        $display("FAIL truth_comb_%0d: got %b want %b", k, y_comb, exp_now);
      end
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if (y !== ve[k]) begin
        failures++;
        $display("FAIL truth_y_%0d: got %b want %b", k, y, ve[k]);
      end
      checks++;
      if (y_comb !== ve[k]) begin
        failures++;
        $display("FAIL truth_comb_settled_%0d: got %b want %b", k, y_comb, ve[k]);
      end
      prev = ve[k];
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp_y;
    @(negedge clk);
    a = 4'b0000;
    b = 4'b0000;
    repeat (3) @(posedge clk);
    #7;
    a = 4'b0001;
    #1;
    checks++;
    if (y !== 4'b0000) begin
      failures++;
      $display("FAIL latency_pre_y: got %b want 0000", y);
    end
    exp_y = (LAT == 1) ? 4'b0001 : 4'b0000;
    checks++;
    if (y_comb !== exp_y) begin
      failures++;
      $display("FAIL latency_comb: got %b want %b", y_comb, exp_y);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== exp_y) begin
      failures++;
      $display("FAIL latency_edge_k: got %b want %b", y, exp_y);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 4'b0001) begin
      failures++;
      $display("FAIL latency_edge_k1: got %b want 0001", y);
    end
  endtask

  task automatic test_x_handling();
    @(negedge clk);
    a = 4'bxxxx;
    b = 4'b1111;
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (y_comb !== 4'b1111) begin
      failures++;
      $display("FAIL x_or_one_comb: got %b want 1111", y_comb);
    end
    checks++;
    if (y !== 4'b1111) begin
      failures++;
      $display("FAIL x_or_one_y: got %b want 1111", y);
    end
  endtask

  task automatic test_midrun_reset();
    logic [3:0] exp_v;
    @(negedge clk);
    a = 4'b1111;
    b = 4'b0000;
    repeat (LAT + 1) @(posedge clk);
    #1;
    checks++;
    if (y !== 4'b1111) begin
      failures++;
      $display("FAIL midrun_pre_y: got %b want 1111", y);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 4'b0000) begin
      failures++;
      $display("FAIL midrun_async_y: got %b want 0000", y);
    end
    exp_v = (LAT == 1) ? 4'b1111 : 4'b0000;
    checks++;
    if (y_comb !== exp_v) begin
      failures++;
      $display("FAIL midrun_comb: got %b want %b", y_comb, exp_v);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (y !== exp_v) begin
      failures++;
      $display("FAIL midrun_edge1_y: got %b want %b", y, exp_v);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 4'b1111) begin
      failures++;
      $display("FAIL midrun_recover_y: got %b want 1111", y);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a        = 4'b0000;
    b        = 4'b0000;
    test_reset();
    test_truth_table();
    test_latency();
    test_x_handling();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
